// File: rtl/bilinear_interp.sv
// Bilinear blend of a 2x2 RGB565 neighbourhood; 4-cycle pipeline with line/frame counters.
// Optional macro BILINEAR_ROUND_EN selects round-half-up normalisation (default: truncation).
module bilinear_interp #(
    parameter int FRAC_W   = 11,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_fsyn,
    input  logic              i_hsyn,
    input  logic [FRAC_W-1:0] iv_fx,
    input  logic [FRAC_W-1:0] iv_fy,
    input  logic [15:0]       iv_b11,
    input  logic [15:0]       iv_b12,
    input  logic [15:0]       iv_b21,
    input  logic [15:0]       iv_b22,
    output logic              o_valid,
    output logic [15:0]       ov_pixel,
    output logic              o_eol,
    output logic              o_eof,
    output logic [10:0]       ov_col,
    output logic [10:0]       ov_row
);

    // All channels are carried at 6 bits; R/B are zero-extended so one datapath serves all three.
    localparam int W = FRAC_W + 7;
    localparam logic [FRAC_W:0] ONE = {1'b1, {FRAC_W{1'b0}}};
`ifdef BILINEAR_ROUND_EN
    localparam logic [W-1:0] RND = W'(1) << (FRAC_W - 1);
`else
    localparam logic [W-1:0] RND = '0;
`endif
    localparam logic [10:0] COL_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] ROW_LAST = 11'(V_ACTIVE - 1);

    logic              r_v0, r_v1, r_v2, r_v3;
    logic [FRAC_W-1:0] r_fx0, r_fy0;
    logic [15:0]       r_b0   [4];
    logic [FRAC_W:0]   r_wx1_1, r_wx0_1, r_wy1_1, r_wy0_1;
    logic [5:0]        r_c1   [4][3];
    logic [FRAC_W:0]   r_wy1_2, r_wy0_2;
    logic [W-1:0]      r_top  [3];
    logic [W-1:0]      r_bot  [3];
    logic [W-1:0]      r_vs   [3];
    logic [10:0]       r_col, r_row;

    logic [5:0]        w_split [4][3];
    logic [W-1:0]      w_top   [3];
    logic [W-1:0]      w_bot   [3];
    logic [W-1:0]      w_topn  [3];
    logic [W-1:0]      w_botn  [3];
    logic [W-1:0]      w_vs    [3];
    logic [W-1:0]      w_ch    [3];
    logic [15:0]       w_pixel;

    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            w_split[n][0] = {1'b0, r_b0[n][15:11]};
            w_split[n][1] = r_b0[n][10:5];
            w_split[n][2] = {1'b0, r_b0[n][4:0]};
        end
        for (int unsigned c = 0; c < 3; c++) begin
            w_top[c]  = W'(r_c1[0][c]) * W'(r_wx1_1) + W'(r_c1[1][c]) * W'(r_wx0_1);
            w_bot[c]  = W'(r_c1[2][c]) * W'(r_wx1_1) + W'(r_c1[3][c]) * W'(r_wx0_1);
            w_topn[c] = (r_top[c] + RND) >> FRAC_W;
            w_botn[c] = (r_bot[c] + RND) >> FRAC_W;
            w_vs[c]   = w_topn[c] * W'(r_wy1_2) + w_botn[c] * W'(r_wy0_2);
            w_ch[c]   = (r_vs[c] + RND) >> FRAC_W;
        end
        w_pixel = {w_ch[0][4:0], w_ch[1][5:0], w_ch[2][4:0]};
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_v0     <= 1'b0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_fx0    <= '0;
            r_fy0    <= '0;
            r_wx1_1  <= '0;
            r_wx0_1  <= '0;
            r_wy1_1  <= '0;
            r_wy0_1  <= '0;
            r_wy1_2  <= '0;
            r_wy0_2  <= '0;
            for (int unsigned n = 0; n < 4; n++) begin
                r_b0[n] <= '0;
                for (int unsigned c = 0; c < 3; c++) r_c1[n][c] <= '0;
            end
            for (int unsigned c = 0; c < 3; c++) begin
                r_top[c] <= '0;
                r_bot[c] <= '0;
                r_vs[c]  <= '0;
            end
            r_col    <= '0;
            r_row    <= '0;
            o_valid  <= 1'b0;
            o_eol    <= 1'b0;
            o_eof    <= 1'b0;
            ov_pixel <= '0;
            ov_col   <= '0;
            ov_row   <= '0;
        end else begin
            // Input register: the sample seen with i_fsyn survives as pixel (0,0).
            r_v0    <= i_hsyn;
            r_fx0   <= iv_fx;
            r_fy0   <= iv_fy;
            r_b0[0] <= iv_b11;
            r_b0[1] <= iv_b12;
            r_b0[2] <= iv_b21;
            r_b0[3] <= iv_b22;

            r_v1    <= r_v0 & ~i_fsyn;
            r_wx1_1 <= ONE - {1'b0, r_fx0};
            r_wx0_1 <= {1'b0, r_fx0};
            r_wy1_1 <= ONE - {1'b0, r_fy0};
            r_wy0_1 <= {1'b0, r_fy0};
            r_c1    <= w_split;

            r_v2    <= r_v1 & ~i_fsyn;
            r_wy1_2 <= r_wy1_1;
            r_wy0_2 <= r_wy0_1;
            r_top   <= w_top;
            r_bot   <= w_bot;

            r_v3    <= r_v2 & ~i_fsyn;
            r_vs    <= w_vs;

            if (i_fsyn) begin
                o_valid <= 1'b0;
                o_eol   <= 1'b0;
                o_eof   <= 1'b0;
                r_col   <= '0;
                r_row   <= '0;
            end else if (r_v3) begin
                o_valid  <= 1'b1;
                ov_pixel <= w_pixel;
                ov_col   <= r_col;
                ov_row   <= r_row;
                o_eol    <= (r_col == COL_LAST);
                o_eof    <= (r_col == COL_LAST) && (r_row == ROW_LAST);
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + 11'd1;
                end else begin
                    r_col <= r_col + 11'd1;
                end
            end else begin
                o_valid <= 1'b0;
                o_eol   <= 1'b0;
                o_eof   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bilinear_interp.sv
// Randomized bench for bilinear_interp against an arithmetic reference model and an
// edge-indexed expectation schedule; small frame geometry (4x3) exercises eol/eof wrap.
module tb_bilinear_interp;

    localparam int FW = 11;
    localparam int HA = 4;
    localparam int VA = 3;
    localparam int NE = 2048;
    localparam int unsigned ONE = 2048;
`ifdef BILINEAR_ROUND_EN
    localparam int unsigned RND = 1024;
`else
    localparam int unsigned RND = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fsyn = 1'b0;
    logic        hsyn = 1'b0;
    logic [10:0] fx = '0, fy = '0;
    logic [15:0] b11 = '0, b12 = '0, b21 = '0, b22 = '0;
    logic        o_valid, o_eol, o_eof;
    logic [15:0] ov_pixel;
    logic [10:0] ov_col, ov_row;

    bilinear_interp #(.FRAC_W(FW), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_fsyn(fsyn), .i_hsyn(hsyn),
        .iv_fx(fx), .iv_fy(fy),
        .iv_b11(b11), .iv_b12(b12), .iv_b21(b21), .iv_b22(b22),
        .o_valid(o_valid), .ov_pixel(ov_pixel), .o_eol(o_eol), .o_eof(o_eof),
        .ov_col(ov_col), .ov_row(ov_row)
    );

    always #5 clk = ~clk;

    int unsigned err_cnt = 0;
    int unsigned chk_cnt = 0;
    int unsigned cyc = 0;
    bit          exp_v [NE];
    bit          fs_at [NE];
    logic [15:0] exp_p [NE];
    int unsigned mcol = 0, mrow = 0;
    logic [15:0] last_pix = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s @edge %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic int unsigned blend(input int unsigned a11, a12, a21, a22, wfx, wfy);
        int unsigned top, bot, v;
        top = (a11 * (ONE - wfx) + a12 * wfx + RND) / ONE;
        bot = (a21 * (ONE - wfx) + a22 * wfx + RND) / ONE;
        v   = top * (ONE - wfy) + bot * wfy;
        return (v + RND) / ONE;
    endfunction

    function automatic logic [15:0] model_pix(input logic [10:0] mfx, mfy,
                                              input logic [15:0] p11, p12, p21, p22);
        int unsigned r, g, b;
        r = blend(p11[15:11], p12[15:11], p21[15:11], p22[15:11], mfx, mfy);
        g = blend(p11[10:5],  p12[10:5],  p21[10:5],  p22[10:5],  mfx, mfy);
        b = blend(p11[4:0],   p12[4:0],   p21[4:0],   p22[4:0],   mfx, mfy);
        return {r[4:0], g[5:0], b[4:0]};
    endfunction

    task automatic check_edge(input int unsigned e);
        if (fs_at[e]) begin
            mcol = 0;
            mrow = 0;
        end
        check_eq("valid", 32'(o_valid), 32'(exp_v[e]));
        if (exp_v[e]) begin
            check_eq("pixel", 32'(ov_pixel), 32'(exp_p[e]));
            check_eq("col", 32'(ov_col), mcol);
            check_eq("row", 32'(ov_row), mrow);
            check_eq("eol", 32'(o_eol), 32'(mcol == HA - 1));
            check_eq("eof", 32'(o_eof), 32'(mcol == HA - 1 && mrow == VA - 1));
            last_pix = exp_p[e];
            if (mcol == HA - 1) begin
                mcol = 0;
                mrow = (mrow == VA - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end else begin
            check_eq("eol_idle", 32'(o_eol), 32'd0);
            check_eq("eof_idle", 32'(o_eof), 32'd0);
            check_eq("pixel_hold", 32'(ov_pixel), 32'(last_pix));
        end
    endtask

    // Called at a negedge; drives one cycle of stimulus and checks the following edge.
    task automatic step(input bit hs, input bit fs, input logic [10:0] sfx, sfy,
                        input logic [15:0] p11, p12, p21, p22);
        int unsigned e;
        hsyn = hs; fsyn = fs; fx = sfx; fy = sfy;
        b11 = p11; b12 = p12; b21 = p21; b22 = p22;
        @(posedge clk);
        cyc++;
        e = cyc;
        if (fs) begin
            for (int k = 0; k < 4; k++) exp_v[e + k] = 1'b0;
            fs_at[e] = 1'b1;
        end
        if (hs) begin
            exp_v[e + 4] = 1'b1;
            exp_p[e + 4] = model_pix(sfx, sfy, p11, p12, p21, p22);
        end
        #1 check_edge(e);
        @(negedge clk);
    endtask

    task automatic rand_step(input bit hs, input bit fs);
        logic [10:0] rfx, rfy;
        rfx = 11'($urandom);
        rfy = 11'($urandom);
        if ($urandom_range(0, 7) == 0) rfx = ($urandom_range(0, 1) == 0) ? 11'd0 : 11'd2047;
        if ($urandom_range(0, 7) == 0) rfy = ($urandom_range(0, 1) == 0) ? 11'd0 : 11'd2047;
        step(hs, fs, rfx, rfy, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) rand_step(1'b0, 1'b0);
    endtask

    // Called at a negedge; outputs must clear without waiting for a clock edge.
    task automatic reset_dut();
        rst_n = 1'b0;
        hsyn  = 1'b0;
        fsyn  = 1'b0;
        #1;
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_pixel", 32'(ov_pixel), 32'd0);
        check_eq("rst_col", 32'(ov_col), 32'd0);
        check_eq("rst_row", 32'(ov_row), 32'd0);
        check_eq("rst_eol", 32'(o_eol), 32'd0);
        check_eq("rst_eof", 32'(o_eof), 32'd0);
        for (int i = int'(cyc) + 1; i < NE; i++) begin
            exp_v[i] = 1'b0;
            fs_at[i] = 1'b0;
        end
        mcol = 0;
        mrow = 0;
        last_pix = '0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        reset_dut();

        step(1'b1, 1'b0, 11'd0, 11'd0, 16'hF81F, 16'h07E0, 16'h07E0, 16'h07E0);
        step(1'b1, 1'b0, 11'd1024, 11'd0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
        step(1'b1, 1'b0, 11'd0, 11'd2047, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000);
        step(1'b1, 1'b0, 11'd2047, 11'd2047, 16'hFFFF, 16'h0000, 16'h0000, 16'h1234);
        idle(6);

        // Two full frames back-to-back, starting from a frame sync.
        rand_step(1'b0, 1'b1);
        for (int i = 0; i < 2 * HA * VA; i++) rand_step(1'b1, 1'b0);
        idle(6);

        // Frame sync with three samples in flight, carrying a sample of its own.
        for (int i = 0; i < 3; i++) rand_step(1'b1, 1'b0);
        rand_step(1'b1, 1'b1);
        idle(6);

        // Reset while outputs are active, then confirm first-sample latency.
        for (int i = 0; i < 6; i++) rand_step(1'b1, 1'b0);
        reset_dut();
        rand_step(1'b1, 1'b0);
        idle(6);

        for (int i = 0; i < 400; i++)
            rand_step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        idle(6);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
